// File: rtl/boot_loader_pkg.sv
// Shared types and sizing helpers for the boot loader and its byte packer.
package boot_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_WRITE,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_e;

   localparam int LEN_BYTES = 2;

   function automatic int bytes_per_word(input int dw);
      return dw / 8;
   endfunction

   // Single-byte words still need a 1-bit counter to stay legal.
   function automatic int byte_cnt_w(input int dw);
      return (dw / 8 > 1) ? $clog2(dw / 8) : 1;
   endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream (valid/ready) and RAM write-port bundles used by boot_loader.
interface boot_stream_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (output in_valid, output in_data, input  in_ready);
   modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

interface boot_mem_if #(
   parameter int DATA_WIDTH = 32,
   parameter int BUS_WIDTH  = 17
);
   logic                  memwrite;
   logic [BUS_WIDTH-1:0]  adr;
   logic [DATA_WIDTH-1:0] writedata;

   modport master (output memwrite, output adr, output writedata);
   modport slave  (input  memwrite, input  adr, input  writedata);
endinterface

// File: rtl/boot_loader_packer.sv
// byte_packer: assembles little-endian bytes into a DATA_WIDTH word.
// last_o flags the byte that completes the word; full_o holds until cleared.
module byte_packer
   import boot_loader_pkg::*;
#(
   parameter int DATA_WIDTH = 32
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr_i,
   input  logic                  shift_i,
   input  logic [7:0]            byte_i,
   output logic [DATA_WIDTH-1:0] word_o,
   output logic                  last_o,
   output logic                  full_o
);
   localparam int B  = bytes_per_word(DATA_WIDTH);
   localparam int CW = byte_cnt_w(DATA_WIDTH);

   logic [B-1:0][7:0] lane_q;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              full_q, full_d;

   assign last_o = shift_i && (cnt_q == CW'(B - 1));
   assign full_o = full_q;
   assign word_o = lane_q;

   always_comb begin
      cnt_d  = cnt_q;
      full_d = full_q;
      if (clr_i) begin
         cnt_d  = '0;
         full_d = 1'b0;
      end else if (shift_i) begin
         cnt_d  = last_o ? '0 : cnt_q + 1'b1;
         full_d = full_q | last_o;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         full_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         full_q <= full_d;
      end
   end

   // New bytes enter the top lane and walk down, so byte 0 ends in lane 0.
   for (genvar i = 0; i < B; i++) begin : g_lane
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            lane_q[i] <= '0;
         end else if (clr_i) begin
            lane_q[i] <= '0;
         end else if (shift_i) begin
            if (i == B - 1) lane_q[i] <= byte_i;
            else            lane_q[i] <= lane_q[(i + 1) % B];
         end
      end
   end

endmodule

// File: rtl/boot_loader.sv
// Streams a length-prefixed word image into RAM, then releases the core.
// Optional trailing XOR checksum byte is enabled by `define BOOT_CHECKSUM_EN.
module boot_loader
   import boot_loader_pkg::*;
#(
   parameter int                   DATA_WIDTH = 32,
   parameter int                   BUS_WIDTH  = 17,
   parameter logic [BUS_WIDTH-1:0] BASE_ADR   = '0
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         start_i,
   boot_stream_if.slave strm,
   boot_mem_if.master   mem,
   output logic         core_reset_o,
   output logic         done_o,
   output logic         error_o
);
   localparam int B  = bytes_per_word(DATA_WIDTH);
   localparam int LB = 8 * LEN_BYTES;
   localparam int LW = (LEN_BYTES > 1) ? $clog2(LEN_BYTES) : 1;
   localparam logic [BUS_WIDTH-1:0] ADR_STEP = BUS_WIDTH'(B);
`ifdef BOOT_CHECKSUM_EN
   localparam state_e S_AFTER = S_CHECK;
`else
   localparam state_e S_AFTER = S_DONE;
`endif

   state_e                state_q, state_d;
   logic [LB-1:0]         wcnt_q, wcnt_d;
   logic [LW-1:0]         len_idx_q, len_idx_d;
   logic [BUS_WIDTH-1:0]  adr_q, adr_d;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [LB-1:0]         len_next;
   logic                  ready, wr, take, restart;
   logic                  pk_shift, pk_clr, pk_last, pk_full;
   logic [DATA_WIDTH-1:0] pk_word;

   assign take     = strm.in_valid & ready;
   assign len_next = {strm.in_data, wcnt_q[LB-1:8]};
   assign pk_clr   = wr | restart;

   byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (pk_clr),
      .shift_i (pk_shift),
      .byte_i  (strm.in_data),
      .word_o  (pk_word),
      .last_o  (pk_last),
      .full_o  (pk_full)
   );

`ifdef BOOT_CHECKSUM_EN
   logic [7:0] csum_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        csum_q <= '0;
      else if (restart)  csum_q <= '0;
      else if (pk_shift) csum_q <= csum_q ^ strm.in_data;
   end

   assign error_o = (state_q == S_ERROR);
`else
   assign error_o = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      len_idx_d = len_idx_q;
      adr_d     = adr_q;
      ready     = 1'b0;
      wr        = 1'b0;
      pk_shift  = 1'b0;
      restart   = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start_i) begin
               state_d   = S_LEN;
               adr_d     = BASE_ADR;
               len_idx_d = '0;
               restart   = 1'b1;
            end
         end
         S_LEN: begin
            ready = 1'b1;
            if (take) begin
               wcnt_d    = len_next;
               len_idx_d = len_idx_q + 1'b1;
               if (len_idx_q == LW'(LEN_BYTES - 1)) begin
                  len_idx_d = '0;
                  state_d   = (len_next == '0) ? S_AFTER : S_DATA;
               end
            end
         end
         S_DATA: begin
            ready = 1'b1;
            if (take) begin
               pk_shift = 1'b1;
               if (pk_last) state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            wr     = pk_full;
            adr_d  = adr_q + ADR_STEP;
            wcnt_d = wcnt_q - 1'b1;
            state_d = (wcnt_q == LB'(1)) ? S_AFTER : S_DATA;
         end
`ifdef BOOT_CHECKSUM_EN
         S_CHECK: begin
            ready = 1'b1;
            if (take) state_d = (strm.in_data == csum_q) ? S_DONE : S_ERROR;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         wcnt_q    <= '0;
         len_idx_q <= '0;
         adr_q     <= BASE_ADR;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         len_idx_q <= len_idx_d;
         adr_q     <= adr_d;
         if (wr) wdata_q <= pk_word;
      end
   end

   // writedata shows the fresh word during WRITE and holds it afterwards.
   assign strm.in_ready  = ready;
   assign mem.memwrite   = wr;
   assign mem.adr        = adr_q;
   assign mem.writedata  = wr ? pk_word : wdata_q;
   assign core_reset_o   = (state_q != S_DONE);
   assign done_o         = (state_q == S_DONE);

endmodule

// File: tb/tb_boot_loader.sv
// Runs three boot_loader instances (base 0, base 0x100, 4-bit wrapping bus) in
// lock-step on one byte stream and checks writes against an address/word model.
module tb_boot_loader;
   localparam int B = 4;
`ifdef BOOT_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   logic        clk = 1'b0, reset = 1'b0, start = 1'b0, vld = 1'b0;
   logic [7:0]  dat = '0;
   logic [2:0]  cr, dn, er;
   int          checks = 0, errors = 0;
   logic [31:0] img[$];
   wr_t         wq0[$], wq1[$], wq2[$];

   always #5 clk = ~clk;

   boot_stream_if s0(), s1(), s2();
   boot_mem_if #(.DATA_WIDTH(32), .BUS_WIDTH(17)) m0(), m1();
   boot_mem_if #(.DATA_WIDTH(32), .BUS_WIDTH(4))  m2();

   assign s0.in_valid = vld;  assign s0.in_data = dat;
   assign s1.in_valid = vld;  assign s1.in_data = dat;
   assign s2.in_valid = vld;  assign s2.in_data = dat;

   boot_loader #(.DATA_WIDTH(32), .BUS_WIDTH(17), .BASE_ADR(17'h0)) d0 (
      .clk(clk), .reset(reset), .start_i(start), .strm(s0), .mem(m0),
      .core_reset_o(cr[0]), .done_o(dn[0]), .error_o(er[0]));
   boot_loader #(.DATA_WIDTH(32), .BUS_WIDTH(17), .BASE_ADR(17'h100)) d1 (
      .clk(clk), .reset(reset), .start_i(start), .strm(s1), .mem(m1),
      .core_reset_o(cr[1]), .done_o(dn[1]), .error_o(er[1]));
   boot_loader #(.DATA_WIDTH(32), .BUS_WIDTH(4), .BASE_ADR(4'hC)) d2 (
      .clk(clk), .reset(reset), .start_i(start), .strm(s2), .mem(m2),
      .core_reset_o(cr[2]), .done_o(dn[2]), .error_o(er[2]));

   always @(negedge clk) begin
      if (m0.memwrite === 1'b1) wq0.push_back('{a: 32'(m0.adr), d: m0.writedata});
      if (m1.memwrite === 1'b1) wq1.push_back('{a: 32'(m1.adr), d: m1.writedata});
      if (m2.memwrite === 1'b1) wq2.push_back('{a: 32'(m2.adr), d: m2.writedata});
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "/in_ready"}, {s0.in_ready, s1.in_ready, s2.in_ready}, 0);
      chk({tag, "/memwrite"}, {m0.memwrite, m1.memwrite, m2.memwrite}, 0);
      chk({tag, "/adr0"}, m0.adr, 0);
      chk({tag, "/adr1"}, m1.adr, 'h100);
      chk({tag, "/adr2"}, m2.adr, 'hC);
      chk({tag, "/writedata"}, m0.writedata | m1.writedata | m2.writedata, 0);
      chk({tag, "/core_reset"}, cr, 3'b111);
      chk({tag, "/done"}, dn, 0);
      chk({tag, "/error"}, er, 0);
   endtask

   // Expected write k lands at (base + k*B) mod 2^bw carrying image word k.
   task automatic chk_q(input string tag, input wr_t q[$], input int base, input int bw,
                        input int nexp);
      chk({tag, "/count"}, 64'(q.size()), 64'(nexp));
      for (int i = 0; i < nexp && i < q.size(); i++) begin
         chk({tag, "/adr"}, q[i].a, 64'((base + i * B) % (1 << bw)));
         chk({tag, "/data"}, q[i].d, img[i]);
      end
   endtask

   task automatic check_writes(input string tag, input int nexp);
      chk_q({tag, "/d0"}, wq0, 0, 17, nexp);
      chk_q({tag, "/d1"}, wq1, 'h100, 17, nexp);
      chk_q({tag, "/d2"}, wq2, 'hC, 4, nexp);
   endtask

   task automatic do_start();
      @(negedge clk);
      wq0.delete(); wq1.delete(); wq2.delete();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start/in_ready", {s0.in_ready, s1.in_ready, s2.in_ready}, 3'b111);
      chk("start/core_reset", cr, 3'b111);
      chk("start/done_error", {dn, er}, 0);
   endtask

   // gap < 0 picks a random idle gap per byte.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int t, g;
      t = 0;
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      vld = 1'b0;
      repeat (g) @(negedge clk);
      vld = 1'b1;
      dat = b;
      while (s0.in_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("accept/in_ready", s0.in_ready, 1);
      @(posedge clk); #1;
      vld = 1'b0;
   endtask

   task automatic send_image(input int n, input int gap, input logic [7:0] flip);
      logic [7:0] x, b;
      logic [31:0] w;
      x = '0;
      send_byte(n[7:0], gap);
      send_byte(n[15:8], gap);
      for (int i = 0; i < n; i++) begin
         w = img[i];
         for (int j = 0; j < B; j++) begin
            b = w[8*j +: 8];
            x = x ^ b;
            send_byte(b, gap);
         end
      end
      if (CK) send_byte(x ^ flip, gap);
   endtask

   // Called in the cycle right after the last stream byte was accepted.
   task automatic check_end(input string tag, input int n, input bit ok);
      chk({tag, "/memwrite_last"}, {m0.memwrite, m1.memwrite, m2.memwrite},
          (!CK && n > 0) ? 3'b111 : 3'b000);
      chk({tag, "/done_early"}, dn, (CK ? ok : (n == 0)) ? 3'b111 : 3'b000);
      @(posedge clk); #1;
      chk({tag, "/done"}, dn, ok ? 3'b111 : 3'b000);
      chk({tag, "/core_reset"}, cr, ok ? 3'b000 : 3'b111);
      chk({tag, "/error"}, er, (CK && !ok) ? 3'b111 : 3'b000);
      repeat (2) @(negedge clk);
      #1;
      check_writes(tag, n);
   endtask

   task automatic rand_image(input int n);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom());
   endtask

   initial begin
      int n;
      // Reset held with a live stream and start request
      vld = 1'b1; dat = 8'hAA; start = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      start = 1'b0; vld = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset("idle");

      // Basic load; d2 also covers the 4-bit wrap 0xC -> 0x0
      img.delete();
      img.push_back(32'h20020005);
      img.push_back(32'h2003000C);
      do_start();
      send_image(2, 0, 8'h00);
      check_end("basic", 2, 1'b1);

      // Same image with a 3-cycle stall before every byte
      do_start();
      send_image(2, 3, 8'h00);
      check_end("stall", 2, 1'b1);

      if (CK) begin
         rand_image(3);
         do_start();
         send_image(3, 0, 8'h01);
         check_end("csum_bad", 3, 1'b0);
         do_start();
         send_image(3, -1, 8'h00);
         check_end("csum_good", 3, 1'b1);
      end

      // Empty image
      img.delete();
      do_start();
      send_image(0, 0, 8'h00);
      check_end("empty", 0, 1'b1);

      // Random images with random gaps
      for (int r = 0; r < 4; r++) begin
         n = int'($urandom_range(1, 6));
         rand_image(n);
         do_start();
         send_image(n, -1, 8'h00);
         check_end("random", n, 1'b1);
      end

      // Abort between the two words of an image
      rand_image(2);
      do_start();
      send_byte(8'd2, 0);
      send_byte(8'd0, 0);
      for (int j = 0; j < B; j++) send_byte(img[0][8*j +: 8], 0);
      @(negedge clk);
      #1;
      reset = 1'b0;
      vld = 1'b1;
      dat = img[1][7:0];
      @(negedge clk);
      chk_reset("abort");
      reset = 1'b1;
      repeat (5) @(negedge clk);
      chk("abort/no_ready", {s0.in_ready, s1.in_ready, s2.in_ready}, 0);
      chk("abort/core_reset", cr, 3'b111);
      vld = 1'b0;
      #1;
      check_writes("abort", 1);

      // A fresh start after the abort loads normally
      do_start();
      send_image(2, 0, 8'h00);
      check_end("reload", 2, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
